abs_diff_err_sweep_ctrl: RTL and testbench
==========================================

# abs_diff_err_sweep_ctrl

Sequential sweep controller for one approximate abs-diff instance. It enumerates every input vector and drives it into the approximate circuit. It compares the circuit's output against an internally computed exact |a − b| and accumulates error statistics against the error threshold. The block sits beside a generated approximate module in the verification/characterisation harness, so a single run gives max error, error sum, threshold violations and pass/fail for that candidate.

## Interface
- IN_W, 8, total DUT input bits; operand a = dut_in[IN_W/2-1:0], operand b = dut_in[IN_W-1:IN_W/2]; IN_W even, ≤ 16
- OUT_W, 4, DUT output width; OUT_W ≥ IN_W/2
- ET, 6, error threshold, OUT_W bits; a vector violates when err > ET

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE
- abort  in  1  terminate a running sweep
- dut_in  out  IN_W  vector driven to the approximate instance (registered)
- dut_out  in  OUT_W  combinational response of the approximate instance to dut_in
- busy  out  1  sweep in progress (SWEEP or DRAIN)
- done  out  1  one-cycle pulse, results final
- aborted  out  1  sticky; set by abort, cleared by next accepted start
- max_err  out  OUT_W  largest |exact − approx| seen
- err_sum  out  IN_W+OUT_W  sum of |exact − approx| over processed vectors
- viol_cnt  out  IN_W+1  count of vectors with err > ET
- first_viol_vec  out  IN_W  index of first violating vector; valid when viol_cnt ≠ 0
- pass  out  1  max_err ≤ ET; meaningful when done is asserted or in IDLE after done

## Operation
- FSM states:
  - IDLE: busy = 0; start → SWEEP; clears all result registers and aborted, and loads vec = 0.
  - SWEEP: dut_in = vec, and vec increments each cycle. After vector 2^IN_W − 1 has been presented → DRAIN. The vector counter is IN_W+1 bits wide to detect the end; dut_in never wraps back to 0 within a sweep.
  - DRAIN: 2 cycles; the pipeline empties. → DONE.
  - DONE: done = 1 for one cycle → IDLE. start is ignored in DONE.
- Pipeline:
  - Stage 1 registers dut_out, the exact value (zero-extended |a − b|, IN_W/2 bits), the vector index and a valid bit.
  - Stage 2 computes err = |exact − approx| at OUT_W bits, then:
    - updates max_err and err_sum;
    - increments viol_cnt if err > ET;
    - loads first_viol_vec on the first violation only.
- pass = (max_err ≤ ET), purely combinational from the registered max_err.
- abort in SWEEP or DRAIN:
  - → IDLE on the next edge; pipeline valids are flushed, so no further accumulation;
  - aborted = 1, no done pulse;
  - results hold their partial values.
- abort in IDLE or DONE is ignored. abort and start together in IDLE: start is ignored.
- start while busy: ignored, with no effect on counters.
- Reset: state = IDLE, dut_in = 0, all outputs and result registers 0. This includes reset mid-sweep; nothing resumes afterwards.

## Timing
- Edge E0 samples start in IDLE. dut_in carries vector k during cycle E0+1+k, for k = 0 … 2^IN_W − 1.
- Vector k is captured at the end of its cycle and accumulated one edge later. Result latency from vector presentation is 2 edges.
- With N = 2^IN_W:
  - busy is high in cycles E0+1 … E0+N+2;
  - done is high in cycle E0+N+3, with busy low;
  - with defaults, done asserts 259 cycles after E0.
- Results change only on accumulation edges and are stable from the done cycle until the next accepted start.
- dut_out must settle within one clock period; no handshake is required from the DUT.

## Test plan
- DUT model = exact abs-diff; start → done 259 cycles after the start edge; max_err = 0, err_sum = 0, viol_cnt = 0, pass = 1.
- DUT tied to 0 → max_err = 15, err_sum = 1360, viol_cnt = 90, first_viol_vec = 7 (a = 7, b = 0), pass = 0.
- DUT = exact with bit 0 inverted → max_err = 1, err_sum = 256, viol_cnt = 0, pass = 1.
- DUT tied to 0; assert abort while dut_in = 100 → IDLE next cycle; no done; aborted = 1. err_sum equals the sum over vectors 0…98 or 0…99 per the 2-stage latency (checked against the model). The next start clears aborted and the results, and the full sweep then reproduces the values of the DUT-tied-to-0 case.
- start pulsed at vector 50 and again during DRAIN → no restart; the done cycle is unchanged. start and abort together in IDLE → stays IDLE.
- rst_n low at vector 200 → immediately busy = 0, done = 0, dut_in = 0, all results 0. After release, a fresh start gives correct results.

Source files
------------

// File: rtl/abs_diff_err_sweep_ctrl_if.sv
// Bundle between the sweep controller, the harness that starts it and the
// approximate abs-diff instance it exercises.
interface abs_diff_err_sweep_ctrl_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
);
    logic                    start;
    logic                    abort;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic                    aborted;
    logic [OUT_W-1:0]        max_err;
    logic [IN_W+OUT_W-1:0]   err_sum;
    logic [IN_W:0]           viol_cnt;
    logic [IN_W-1:0]         first_viol_vec;
    logic                    pass;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, aborted, max_err, err_sum, viol_cnt,
               first_viol_vec, pass
    );

    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, aborted, max_err, err_sum, viol_cnt,
               first_viol_vec, pass
    );
endinterface

// File: rtl/abs_diff_err_sweep_ctrl.sv
// Exhaustive sweep of one approximate abs-diff candidate: drives every input
// vector, compares against exact |a - b| and accumulates error statistics.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results hold their last values
// S_SWEEP | presenting vectors 0 .. 2^IN_W-1, one per cycle
// S_DRAIN | two cycles letting the compare pipeline empty
// S_DONE  | one-cycle done pulse, results final
module abs_diff_err_sweep_ctrl #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int ET    = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    abs_diff_err_sweep_ctrl_if.slave    bus
);

    localparam int HALF = IN_W / 2;
    localparam logic [IN_W:0]    VEC_END = {1'b1, {IN_W{1'b0}}};
    localparam logic [OUT_W-1:0] ET_V    = OUT_W'(ET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [IN_W:0]           r_vec;
    logic [IN_W-1:0]         r_dut_in;
    logic                    r_drain_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_aborted;

    logic                    r_s1_valid;
    logic [OUT_W-1:0]        r_s1_approx;
    logic [HALF-1:0]         r_s1_exact;
    logic [IN_W-1:0]         r_s1_idx;

    logic [OUT_W-1:0]        r_max_err;
    logic [IN_W+OUT_W-1:0]   r_err_sum;
    logic [IN_W:0]           r_viol_cnt;
    logic [IN_W-1:0]         r_first_viol_vec;

    logic [HALF-1:0]         w_a;
    logic [HALF-1:0]         w_b;
    logic [HALF-1:0]         w_exact;
    logic [OUT_W-1:0]        w_exact_ext;
    logic [OUT_W-1:0]        w_err;
    logic                    w_viol;
    logic                    w_abort_run;
    logic                    w_start_ok;
    logic                    w_acc;

    assign w_a     = r_dut_in[HALF-1:0];
    assign w_b     = r_dut_in[IN_W-1:HALF];
    assign w_exact = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);

    assign w_exact_ext = OUT_W'(r_s1_exact);
    assign w_err       = (w_exact_ext >= r_s1_approx) ? (w_exact_ext - r_s1_approx)
                                                      : (r_s1_approx - w_exact_ext);
    assign w_viol      = (w_err > ET_V);

    assign w_abort_run = bus.abort && ((r_state == S_SWEEP) || (r_state == S_DRAIN));
    assign w_start_ok  = (r_state == S_IDLE) && bus.start && !bus.abort;
    // An abort edge also suppresses the stage-2 update, so nothing in flight lands.
    assign w_acc       = r_s1_valid && !w_abort_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_vec            <= '0;
            r_dut_in         <= '0;
            r_drain_cnt      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_aborted        <= 1'b0;
            r_s1_valid       <= 1'b0;
            r_s1_approx      <= '0;
            r_s1_exact       <= '0;
            r_s1_idx         <= '0;
            r_max_err        <= '0;
            r_err_sum        <= '0;
            r_viol_cnt       <= '0;
            r_first_viol_vec <= '0;
        end else begin
            r_done     <= 1'b0;
            r_s1_valid <= 1'b0;

            if (w_acc) begin
                if (w_err > r_max_err) begin
                    r_max_err <= w_err;
                end
                r_err_sum <= r_err_sum + (IN_W+OUT_W)'(w_err);
                if (w_viol) begin
                    r_viol_cnt <= r_viol_cnt + (IN_W+1)'(1);
                    if (r_viol_cnt == '0) begin
                        r_first_viol_vec <= r_s1_idx;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state          <= S_SWEEP;
                        r_busy           <= 1'b1;
                        r_aborted        <= 1'b0;
                        r_dut_in         <= '0;
                        r_vec            <= (IN_W+1)'(1);
                        r_max_err        <= '0;
                        r_err_sum        <= '0;
                        r_viol_cnt       <= '0;
                        r_first_viol_vec <= '0;
                    end
                end

                S_SWEEP: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_s1_valid  <= 1'b1;
                        r_s1_approx <= bus.dut_out;
                        r_s1_exact  <= w_exact;
                        r_s1_idx    <= r_dut_in;
                        // dut_in parks on the last vector rather than wrapping.
                        if (r_vec == VEC_END) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= 1'b0;
                        end else begin
                            r_dut_in <= r_vec[IN_W-1:0];
                            r_vec    <= r_vec + (IN_W+1)'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (r_drain_cnt) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_in         = r_dut_in;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.aborted        = r_aborted;
    assign bus.max_err        = r_max_err;
    assign bus.err_sum        = r_err_sum;
    assign bus.viol_cnt       = r_viol_cnt;
    assign bus.first_viol_vec = r_first_viol_vec;
    assign bus.pass           = (r_max_err <= ET_V);

endmodule

// File: tb/tb_abs_diff_err_sweep_ctrl.sv
// Bench for abs_diff_err_sweep_ctrl: a behavioural approximate DUT drives
// dut_out and a loop-based reference computes the expected statistics.
module tb_abs_diff_err_sweep_ctrl;

    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int ET    = 6;
    localparam int N     = 1 << IN_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    abs_diff_err_sweep_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    abs_diff_err_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int mode     = 0;   // 0 exact, 1 tied to 0, 2 exact with LSB inverted, 3 random table
    int lut[N];

    function automatic int exact_of(int v);
        int a = v % 16;
        int b = v / 16;
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int approx_of(int v);
        case (mode)
            0:       return exact_of(v);
            1:       return 0;
            2:       return exact_of(v) ^ 1;
            default: return lut[v];
        endcase
    endfunction

    assign bus.dut_out = OUT_W'(approx_of(int'(bus.dut_in)));

    task automatic ref_stats(input int last, output int mx, output int sum,
                             output int vc, output int fv);
        mx = 0; sum = 0; vc = 0; fv = 0;
        for (int v = 0; v <= last; v++) begin
            int e = exact_of(v) - approx_of(v);
            if (e < 0) e = -e;
            if (e > mx) mx = e;
            sum += e;
            if (e > ET) begin
                if (vc == 0) fv = v;
                vc++;
            end
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b aborted=%b expected 0 0 0",
                     bus.busy, bus.done, bus.aborted);
        end
        checks++;
        if (int'(bus.dut_in) !== 0 || int'(bus.err_sum) !== 0 || int'(bus.viol_cnt) !== 0 ||
            int'(bus.max_err) !== 0 || int'(bus.first_viol_vec) !== 0) begin
            failures++;
            $display("FAIL reset_data: dut_in=%0d max=%0d sum=%0d viol=%0d first=%0d expected all 0",
                     bus.dut_in, bus.max_err, bus.err_sum, bus.viol_cnt, bus.first_viol_vec);
        end
        #3 rst_n = 1'b1;
    endtask

    task automatic test_full_sweep(input int m, input string name);
        int mx, sum, vc, fv, cyc;
        mode = m;
        ref_stats(N - 1, mx, sum, vc, fv);
        do_start();
        cyc = 1;
        checks++;
        if (bus.busy !== 1'b1 || int'(bus.dut_in) !== 0 || bus.aborted !== 1'b0 ||
            int'(bus.err_sum) !== 0 || int'(bus.max_err) !== 0 || int'(bus.viol_cnt) !== 0) begin
            failures++;
            $display("FAIL %s_first_cycle: busy=%b dut_in=%0d aborted=%b sum=%0d max=%0d viol=%0d expected 1 0 0 0 0 0",
                     name, bus.busy, bus.dut_in, bus.aborted, bus.err_sum, bus.max_err, bus.viol_cnt);
        end
        while (bus.done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== N + 3 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_cycle: done at %0d busy=%b expected %0d busy=0", name, cyc, bus.busy, N + 3);
        end
        checks++;
        if (int'(bus.max_err) !== mx || int'(bus.err_sum) !== sum) begin
            failures++;
            $display("FAIL %s_err: max=%0d sum=%0d expected max=%0d sum=%0d",
                     name, bus.max_err, bus.err_sum, mx, sum);
        end
        checks++;
        if (int'(bus.viol_cnt) !== vc || (vc != 0 && int'(bus.first_viol_vec) !== fv)) begin
            failures++;
            $display("FAIL %s_viol: viol=%0d first=%0d expected viol=%0d first=%0d",
                     name, bus.viol_cnt, bus.first_viol_vec, vc, fv);
        end
        checks++;
        if (bus.pass !== (mx <= ET)) begin
            failures++;
            $display("FAIL %s_pass: pass=%b expected %b", name, bus.pass, (mx <= ET));
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.err_sum) !== sum) begin
            failures++;
            $display("FAIL %s_after_done: done=%b busy=%b sum=%0d expected 0 0 %0d",
                     name, bus.done, bus.busy, bus.err_sum, sum);
        end
    endtask

    task automatic test_abort(input int m, input int at, input string name);
        int mx, sum, vc, fv, guard, done_seen;
        mode = m;
        // Vector at-1 is still in stage 1 on the abort edge and is discarded.
        ref_stats(at - 2, mx, sum, vc, fv);
        do_start();
        guard = 0;
        while (int'(bus.dut_in) !== at && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (int'(bus.dut_in) !== at) begin
            failures++;
            $display("FAIL %s_reach: dut_in=%0d expected %0d", name, bus.dut_in, at);
        end
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL %s_state: busy=%b aborted=%b done=%b expected 0 1 0",
                     name, bus.busy, bus.aborted, bus.done);
        end
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL %s_no_done: done/busy seen %0d cycles expected 0", name, done_seen);
        end
        checks++;
        if (int'(bus.max_err) !== mx || int'(bus.err_sum) !== sum || int'(bus.viol_cnt) !== vc ||
            (vc != 0 && int'(bus.first_viol_vec) !== fv)) begin
            failures++;
            $display("FAIL %s_partial: max=%0d sum=%0d viol=%0d first=%0d expected %0d %0d %0d %0d",
                     name, bus.max_err, bus.err_sum, bus.viol_cnt, bus.first_viol_vec, mx, sum, vc, fv);
        end
    endtask

    task automatic test_back_to_back();
        int mx, sum, vc, fv, cyc;
        mode = 1;
        ref_stats(N - 1, mx, sum, vc, fv);
        do_start();
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 400) begin
            bus.start = (cyc == 51 || cyc == N + 1) ? 1'b1 : 1'b0;
            if (cyc == 51) begin
                checks++;
                if (int'(bus.dut_in) !== 50) begin
                    failures++;
                    $display("FAIL restart_vec50: dut_in=%0d expected 50", bus.dut_in);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (cyc !== N + 3 || int'(bus.err_sum) !== sum || int'(bus.viol_cnt) !== vc) begin
            failures++;
            $display("FAIL restart_ignored: done at %0d sum=%0d viol=%0d expected %0d %0d %0d",
                     cyc, bus.err_sum, bus.viol_cnt, N + 3, sum, vc);
        end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b0 || int'(bus.err_sum) !== sum ||
            int'(bus.max_err) !== mx) begin
            failures++;
            $display("FAIL start_abort_idle: busy=%b aborted=%b sum=%0d max=%0d expected 0 0 %0d %0d",
                     bus.busy, bus.aborted, bus.err_sum, bus.max_err, sum, mx);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < N; v++) lut[v] = int'($urandom_range(0, 15));
            test_full_sweep(3, "random");
        end
        for (int v = 0; v < N; v++) lut[v] = int'($urandom_range(0, 15));
        test_abort(3, int'($urandom_range(10, 240)), "random_abort");
        test_full_sweep(3, "random_after_abort");
    endtask

    task automatic test_reset_mid();
        int guard;
        for (int v = 0; v < N; v++) lut[v] = int'($urandom_range(0, 15));
        mode = 3;
        do_start();
        guard = 0;
        while (int'(bus.dut_in) !== 200 && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || int'(bus.dut_in) !== 0 || bus.aborted !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ctrl: busy=%b done=%b dut_in=%0d aborted=%b expected 0 0 0 0",
                     bus.busy, bus.done, bus.dut_in, bus.aborted);
        end
        checks++;
        if (int'(bus.max_err) !== 0 || int'(bus.err_sum) !== 0 || int'(bus.viol_cnt) !== 0 ||
            int'(bus.first_viol_vec) !== 0) begin
            failures++;
            $display("FAIL midreset_data: max=%0d sum=%0d viol=%0d first=%0d expected all 0",
                     bus.max_err, bus.err_sum, bus.viol_cnt, bus.first_viol_vec);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || int'(bus.dut_in) !== 0) begin
            failures++;
            $display("FAIL midreset_hold: busy=%b dut_in=%0d expected 0 0", bus.busy, bus.dut_in);
        end
        rst_n = 1'b1;
        test_full_sweep(3, "after_reset");
    endtask

    initial begin
        test_reset();
        test_full_sweep(0, "exact");
        test_full_sweep(1, "zero");
        test_full_sweep(2, "lsb_flip");
        test_abort(1, 100, "abort100");
        test_full_sweep(1, "zero_after_abort");
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
